// File: rtl/bus_ram_responder_if.sv
// Bus bundle between an initiator and the RAM responder: request/ready
// handshake plus address, write data/mask and read data/error return.
interface bus_ram_responder_if;
    logic        bus_rw;
    logic        bus_request;
    logic        bus_ready;
    logic [31:0] bus_address;
    logic [31:0] bus_rdata;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wmask;
    logic        error;

    modport master (
        output bus_rw, bus_request, bus_address, bus_wdata, bus_wmask,
        input  bus_ready, bus_rdata, error
    );

    modport slave (
        input  bus_rw, bus_request, bus_address, bus_wdata, bus_wmask,
        output bus_ready, bus_rdata, error
    );
endinterface

// File: rtl/bus_ram_responder.sv
// Word-addressed RAM behind a request/ready bus with a fixed number of
// wait states, byte-masked writes and out-of-range error reporting.
module bus_ram_responder #(
    parameter int unsigned ADDR_BITS   = 12,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] BASE        = 32'h0000_0000
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_bus_rw,
    input  logic        i_bus_request,
    output logic        o_bus_ready,
    input  logic [31:0] i_bus_address,
    output logic [31:0] o_bus_rdata,
    input  logic [31:0] i_bus_wdata,
    input  logic [3:0]  i_bus_wmask,
    output logic        o_error
);

    localparam int unsigned DEPTH     = 1 << ADDR_BITS;
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES);
    localparam logic [32:0] SPAN      = 33'd4 << ADDR_BITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [3:0]             count_q;
    logic [3:0]             count_d;
    logic [31:0]            rd_word_q;
    logic [31:0]            mem [DEPTH];

    logic [31:0]            offset_s;
    logic                   below_s;
    logic                   above_s;
    logic                   in_range_s;
    logic [ADDR_BITS-1:0]   word_idx_s;
    logic                   ack_live_s;
    logic                   wr_en_s;
    logic                   rd_en_s;

    // Address decode; the 33-bit compare keeps the top boundary exact
    // even when the window ends right at 2^32.
    always_comb begin
        offset_s   = i_bus_address - BASE;
        below_s    = (i_bus_address < BASE);
        above_s    = ({1'b0, offset_s} >= SPAN);
        in_range_s = !below_s && !above_s;
        word_idx_s = offset_s[ADDR_BITS+1:2];
    end

    // Next-state and wait counter; a dropped request abandons the transfer.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (i_bus_request) begin
                    count_d = WAIT_LOAD;
                    state_d = (WAIT_LOAD != 4'd0) ? ST_WAIT : ST_ACK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!i_bus_request) begin
                    state_d = ST_IDLE;
                    count_d = 4'd0;
                end else if (count_q <= 4'd1) begin
                    state_d = ST_ACK;
                    count_d = 4'd0;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
                count_d = 4'd0;
            end
            default: begin
                state_d = ST_IDLE;
                count_d = 4'd0;
            end
        endcase
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            count_q <= 4'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Completion is only visible while the initiator still holds request.
    always_comb begin
        ack_live_s = (state_q == ST_ACK) && i_bus_request;
        wr_en_s    = ack_live_s && i_bus_rw && in_range_s && i_reset;
        rd_en_s    = (state_d == ST_ACK);
    end

    // RAM array: masked write at the end of ACK, read registered on ACK entry.
    always_ff @(posedge i_clock) begin
        if (wr_en_s) begin
            for (int b = 0; b < 4; b++) begin
                if (i_bus_wmask[b]) begin
                    mem[word_idx_s][8*b +: 8] <= i_bus_wdata[8*b +: 8];
                end
            end
        end
        if (rd_en_s) begin
            rd_word_q <= mem[word_idx_s];
        end
    end

    // Bus return path; rdata is forced to zero outside a live in-range read.
    always_comb begin
        o_bus_ready = ack_live_s;
        o_error     = ack_live_s && !in_range_s;
        if (ack_live_s && !i_bus_rw && in_range_s) begin
            o_bus_rdata = rd_word_q;
        end else begin
            o_bus_rdata = 32'd0;
        end
    end

endmodule

// File: tb/tb_bus_ram_responder.sv
// Randomised transaction bench for bus_ram_responder against a word-array
// reference model; two instances cover wait-state and base-offset variants.
module tb_bus_ram_responder;

    localparam int          WS_A   = 2;
    localparam int          WS_B   = 0;
    localparam int          AB_A   = 12;
    localparam int          AB_B   = 4;
    localparam logic [31:0] BASE_A = 32'h0000_0000;
    localparam logic [31:0] BASE_B = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bus_ram_responder_if ifa ();
    bus_ram_responder_if ifb ();

    bus_ram_responder #(.ADDR_BITS(AB_A), .WAIT_STATES(WS_A), .BASE(BASE_A)) dut_a (
        .i_clock(clk), .i_reset(rst_n), .i_bus_rw(ifa.bus_rw),
        .i_bus_request(ifa.bus_request), .o_bus_ready(ifa.bus_ready),
        .i_bus_address(ifa.bus_address), .o_bus_rdata(ifa.bus_rdata),
        .i_bus_wdata(ifa.bus_wdata), .i_bus_wmask(ifa.bus_wmask), .o_error(ifa.error)
    );

    bus_ram_responder #(.ADDR_BITS(AB_B), .WAIT_STATES(WS_B), .BASE(BASE_B)) dut_b (
        .i_clock(clk), .i_reset(rst_n), .i_bus_rw(ifb.bus_rw),
        .i_bus_request(ifb.bus_request), .o_bus_ready(ifb.bus_ready),
        .i_bus_address(ifb.bus_address), .o_bus_rdata(ifb.bus_rdata),
        .i_bus_wdata(ifb.bus_wdata), .i_bus_wmask(ifb.bus_wmask), .o_error(ifb.error)
    );

    int          total = 0;
    int          bad   = 0;
    int          txn_no = 0;
    logic [31:0] model_a [4096];
    logic [31:0] model_b [16];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int which, input logic req, input logic rw,
                         input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm);
        if (which == 0) begin
            ifa.bus_request = req; ifa.bus_rw = rw; ifa.bus_address = a;
            ifa.bus_wdata = wd; ifa.bus_wmask = wm;
        end else begin
            ifb.bus_request = req; ifb.bus_rw = rw; ifb.bus_address = a;
            ifb.bus_wdata = wd; ifb.bus_wmask = wm;
        end
    endtask

    task automatic sample(input int which, output logic rdy, output logic [31:0] rd, output logic err);
        if (which == 0) begin
            rdy = ifa.bus_ready; rd = ifa.bus_rdata; err = ifa.error;
        end else begin
            rdy = ifb.bus_ready; rd = ifb.bus_rdata; err = ifb.error;
        end
    endtask

    function automatic bit in_range(input int which, input logic [31:0] a);
        longint base;
        longint span;
        base = (which == 0) ? longint'(BASE_A) : longint'(BASE_B);
        span = 4 * (longint'(1) << ((which == 0) ? AB_A : AB_B));
        return (longint'(a) >= base) && (longint'(a) < base + span);
    endfunction

    function automatic int word_of(input int which, input logic [31:0] a);
        return int'((a - ((which == 0) ? BASE_A : BASE_B)) >> 2);
    endfunction

    function automatic logic [31:0] model_rd(input int which, input logic [31:0] a);
        return (which == 0) ? model_a[word_of(which, a)] : model_b[word_of(which, a)];
    endfunction

    task automatic model_wr(input int which, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm);
        logic [31:0] w;
        w = model_rd(which, a);
        for (int b = 0; b < 4; b++) begin
            if (wm[b]) w[8*b +: 8] = wd[8*b +: 8];
        end
        if (which == 0) model_a[word_of(which, a)] = w;
        else            model_b[word_of(which, a)] = w;
    endtask

    // One transaction; drop >= 1 lowers request from that cycle on. Outside the
    // ACK cycle rw/wdata/wmask carry junk, since only ACK-cycle values count.
    task automatic run_txn(input int which, input logic rw, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] wm, input int drop);
        int          lat;
        bit          aborted;
        bit          inr;
        logic        rdy;
        logic        err;
        logic [31:0] rd;
        logic [31:0] exp_rd;
        string       t;
        lat     = ((which == 0) ? WS_A : WS_B) + 1;
        aborted = (drop >= 1) && (drop <= lat);
        inr     = in_range(which, a);
        exp_rd  = (!rw && inr) ? model_rd(which, a) : 32'd0;
        txn_no++;
        for (int c = 0; c <= lat + 1; c++) begin
            @(posedge clk); #1;
            if (c == lat)
                drive(which, !(aborted && c >= drop), rw, a, wd, wm);
            else
                drive(which, (c < lat) && !(aborted && c >= drop), 1'($urandom_range(0, 1)),
                      a, $urandom, 4'($urandom_range(0, 15)));
            @(negedge clk);
            sample(which, rdy, rd, err);
            t = $sformatf("t%0d/%0d c%0d", txn_no, which, c);
            if (c == lat && !aborted) begin
                check_val({t, " ready"}, {31'd0, rdy}, 32'd1);
                check_val({t, " error"}, {31'd0, err}, {31'd0, !inr});
                check_val({t, " rdata"}, rd, exp_rd);
            end else begin
                check_val({t, " ready"}, {31'd0, rdy}, 32'd0);
                check_val({t, " error"}, {31'd0, err}, 32'd0);
                check_val({t, " rdata"}, rd, 32'd0);
            end
        end
        if (!aborted && rw && inr) model_wr(which, a, wd, wm);
    endtask

    function automatic logic [31:0] pick_addr(input int which);
        logic [31:0] lo;
        lo = 32'($urandom_range(0, 3));
        if ($urandom_range(0, 9) < 8) begin
            if (which == 0)
                return ($urandom_range(0, 16) == 16) ? (32'h0000_3FFC | lo)
                                                     : (32'($urandom_range(0, 15)) * 32'd4 + lo);
            return BASE_B + 32'($urandom_range(0, 15)) * 32'd4 + lo;
        end
        if (which == 0)
            return ($urandom_range(0, 1) == 1) ? (32'h0000_4000 + 32'($urandom_range(0, 1023)) * 32'd4)
                                               : (32'hFFFF_FF00 | 32'($urandom_range(0, 255)));
        return ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 32'hFF))
                                           : (32'h0000_0140 + 32'($urandom_range(0, 255)));
    endfunction

    logic        rdy;
    logic        err;
    logic [31:0] rd;
    int          nready;
    logic [31:0] keep;

    initial begin
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            sample(w, rdy, rd, err);
            check_val($sformatf("reset ready %0d", w), {31'd0, rdy}, 32'd0);
            check_val($sformatf("reset rdata %0d", w), rd, 32'd0);
            check_val($sformatf("reset error %0d", w), {31'd0, err}, 32'd0);
        end
        rst_n = 1'b1;

        // RAM is not reset, so give every word the bench reads a known value.
        for (int i = 0; i < 16; i++) begin
            run_txn(0, 1'b1, 32'(i * 4), $urandom, 4'hF, -1);
            run_txn(1, 1'b1, BASE_B + 32'(i * 4), $urandom, 4'hF, -1);
        end
        run_txn(0, 1'b1, 32'h0000_3FFC, $urandom, 4'hF, -1);

        run_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, -1);
        run_txn(0, 1'b0, 32'h10, 32'd0, 4'h0, -1);
        run_txn(0, 1'b1, 32'h10, 32'h0000_00AA, 4'h1, -1);
        check_val("mask model", model_a[4], 32'hDEADBEAA);
        run_txn(0, 1'b0, 32'h10, 32'd0, 4'h0, -1);
        run_txn(0, 1'b1, 32'h20, 32'h1234_5678, 4'hF, 1);
        run_txn(0, 1'b0, 32'h20, 32'd0, 4'h0, -1);
        run_txn(0, 1'b0, 32'h4000, 32'd0, 4'h0, -1);
        run_txn(0, 1'b1, 32'h4000, 32'h5555_AAAA, 4'hF, -1);
        run_txn(0, 1'b0, 32'h0, 32'd0, 4'h0, -1);
        run_txn(0, 1'b1, 32'h8, 32'hFFFF_FFFF, 4'h0, -1);
        run_txn(0, 1'b0, 32'h8, 32'd0, 4'h0, -1);
        run_txn(0, 1'b0, 32'h3FFC, 32'd0, 4'h0, -1);
        run_txn(1, 1'b1, 32'h0FC, 32'h0BAD_0BAD, 4'hF, -1);
        run_txn(1, 1'b1, 32'h140, 32'h0BAD_0BAD, 4'hF, -1);
        run_txn(1, 1'b0, 32'h100, 32'd0, 4'h0, -1);
        run_txn(1, 1'b0, 32'h13C, 32'd0, 4'h0, -1);
        run_txn(1, 1'b1, 32'h104, 32'hA5A5_0001, 4'h6, 1);

        // Request held high with no wait states: a completion every second cycle.
        nready = 0;
        for (int c = 0; c <= 6; c++) begin
            @(posedge clk); #1;
            drive(1, c < 6, 1'b0, 32'h104, 32'd0, 4'h0);
            @(negedge clk);
            sample(1, rdy, rd, err);
            if (rdy) nready++;
            check_val($sformatf("hold ready c%0d", c), {31'd0, rdy}, {31'd0, (c == 1 || c == 3 || c == 5)});
            check_val($sformatf("hold rdata c%0d", c), rd, (c == 1 || c == 3 || c == 5) ? model_b[1] : 32'd0);
        end
        check_val("hold ready count", 32'(nready), 32'd3);

        // Reset during WAIT of a write; the restarted read must take full latency.
        keep = model_a[9];
        for (int c = 0; c <= 6; c++) begin
            @(posedge clk); #1;
            rst_n = (c != 1);
            if (c < 2) drive(0, 1'b1, 1'b1, 32'h24, 32'hCAFE_F00D, 4'hF);
            else       drive(0, c <= 5, 1'b0, 32'h24, 32'd0, 4'h0);
            @(negedge clk);
            sample(0, rdy, rd, err);
            check_val($sformatf("rst-wait ready c%0d", c), {31'd0, rdy}, {31'd0, c == 5});
            check_val($sformatf("rst-wait rdata c%0d", c), rd, (c == 5) ? keep : 32'd0);
        end

        // Reset coinciding with the ACK cycle of a write must block the commit.
        keep = model_a[10];
        for (int c = 0; c <= 4; c++) begin
            @(posedge clk); #1;
            rst_n = (c != 3);
            drive(0, c <= 3, 1'b1, 32'h28, 32'h0F0F_0F0F, 4'hF);
            @(negedge clk);
            sample(0, rdy, rd, err);
            if (c != 3) check_val($sformatf("rst-ack ready c%0d", c), {31'd0, rdy}, 32'd0);
        end
        rst_n = 1'b1;
        run_txn(0, 1'b0, 32'h28, 32'd0, 4'h0, -1);
        check_val("rst-ack model kept", model_a[10], keep);

        for (int n = 0; n < 300; n++) begin
            int          w;
            int          lat;
            logic [31:0] a;
            w   = $urandom_range(0, 1);
            lat = ((w == 0) ? WS_A : WS_B) + 1;
            a   = pick_addr(w);
            run_txn(w, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, lat)) : -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_ram_responder.md
BUS_RAM_RESPONDER -- requirements
Module: bus_ram_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 12, meaning RAM depth is 2^ADDR_BITS 32-bit words.
REQ-002 SHALL have parameter WAIT_STATES, default 2, meaning extra cycles inserted before ready; legal range 0..15.
REQ-003 SHALL have parameter BASE, default 32'h0000_0000, meaning byte address of word 0.
REQ-004 SHALL use a single clock; reset is synchronous and active-low.
REQ-005 SHALL have port i_clock, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port i_reset, input, 1 bit: synchronous reset, active-low.
REQ-007 SHALL have port i_bus_rw, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have port i_bus_request, input, 1 bit: the initiator holds it high until it sees ready.
REQ-009 SHALL have port o_bus_ready, output, 1 bit: single-cycle completion strobe.
REQ-010 SHALL have port i_bus_address, input, 32 bits: byte address; bits [1:0] are ignored.
REQ-011 SHALL have port o_bus_rdata, output, 32 bits: read data, valid only while o_bus_ready=1.
REQ-012 SHALL have port i_bus_wdata, input, 32 bits: write data.
REQ-013 SHALL have port i_bus_wmask, input, 4 bits: byte enables; bit n covers bits [8n+7:8n].
REQ-014 SHALL have port o_error, output, 1 bit: pulses together with o_bus_ready on an out-of-range access.

Function
REQ-015 SHALL implement an FSM with three states:
- IDLE
- WAIT
- ACK
REQ-016 IDLE: with i_bus_request=1, SHALL load the counter with WAIT_STATES and go to WAIT if WAIT_STATES>0, else go to ACK; otherwise SHALL stay in IDLE.
REQ-017 WAIT: SHALL decrement the counter each cycle and go to ACK on the cycle the counter reaches 1.
REQ-018 ACK: SHALL drive o_bus_ready=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-019 Latency from the first request cycle to the ready cycle SHALL be WAIT_STATES+1 cycles.
REQ-020 The RAM read SHALL be synchronous, issued on the cycle the FSM enters ACK, using the address present on that cycle.
REQ-021 o_bus_rdata SHALL equal the word at word index (i_bus_address-BASE)>>2 during ACK for reads, and SHALL be 0 in all other cycles.
REQ-022 A write SHALL commit at the clock edge that ends ACK, using the live i_bus_address, i_bus_wdata and i_bus_wmask; only bytes with mask=1 change.
REQ-023 A write with i_bus_wmask=4'b0000 SHALL complete normally with no RAM change.
REQ-024 Abort: if i_bus_request is 0 in WAIT or ACK, the FSM SHALL return to IDLE next cycle with o_bus_ready=0, no write, no error.
REQ-025 No ready SHALL ever be issued without the request being high in the same cycle.
REQ-026 One request SHALL produce exactly one ready.
REQ-027 A request still high in the cycle after ACK SHALL be treated as a new transaction starting in IDLE.
REQ-028 Back-to-back transactions SHALL therefore complete no more often than every WAIT_STATES+2 cycles.
REQ-029 Read-after-write to the same word in back-to-back transactions SHALL return the newly written data.
REQ-030 Out of range means address<BASE or address>=BASE+4*2^ADDR_BITS.
REQ-031 An out-of-range access SHALL still complete with ready at normal latency, o_bus_rdata=0, o_error=1, and no RAM write.
REQ-032 Address arithmetic SHALL be 32-bit unsigned; BASE+4*2^ADDR_BITS wrapping past 2^32 is illegal and not checked.
REQ-033 If i_bus_rw, address or data change between request start and ACK, only the ACK-cycle values SHALL be used.

Reset
REQ-034 While i_reset=0 at a rising edge, the responder SHALL enter IDLE with counter=0, o_bus_ready=0, o_bus_rdata=0 and o_error=0.
REQ-035 Reset asserted mid-transaction SHALL abort it with no write; a write in its ACK cycle at a reset edge SHALL NOT commit.
REQ-036 RAM contents SHALL NOT be reset.

Verification
REQ-037 With WAIT_STATES=2, a request (write, address 0x10, wdata 0xDEADBEEF, wmask 1111) held from cycle 0 -> ready only in cycle 3; a following read of 0x10 -> rdata 0xDEADBEEF at its ready.
REQ-038 Word 0x10 holds 0xDEADBEEF; write wdata 0x000000AA with wmask 0001, then read 0x10 -> 0xDEADBEAA.
REQ-039 Write 0x12345678 to 0x20, with request dropped in cycle 1 (WAIT) -> no ready; a later read of 0x20 returns its prior value.
REQ-040 With ADDR_BITS=12 and BASE=0, read 0x4000 -> ready, o_error=1, rdata=0; write 0x4000 -> ready, o_error=1, RAM unchanged.
REQ-041 With WAIT_STATES=0, request held continuously with 3 reads -> readies in cycles 1, 3, 5, exactly 3 in total.
REQ-042 Reset driven low during WAIT of a write -> o_bus_ready=0 next cycle, FSM in IDLE, target word unchanged.
